// File: rtl/ysyx_22050078_ifu_pkg.sv
// Shared widths, FSM state encoding and fault-cause codes for the instruction fetch unit.
package ysyx_22050078_ifu_pkg;

  localparam int CPU_WIDTH  = 64;
  localparam int INST_WIDTH = 32;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    IFU_FC_NONE     = 2'd0,
    IFU_FC_MISALIGN = 2'd1,
    IFU_FC_BUSERR   = 2'd2,
    IFU_FC_TIMEOUT  = 2'd3
  } ifu_fc_e;

  // Pick the 32-bit word of an aligned doubleword addressed by pc[2].
  function automatic logic [INST_WIDTH-1:0] ifu_sel_inst(input logic [CPU_WIDTH-1:0] data,
                                                         input logic            hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050078_ifu_if.sv
// Handshake bundle around the fetch unit: PC in, memory read bus, instruction out to the IDU.
interface ysyx_22050078_ifu_if #(
  parameter int CPU_WIDTH  = ysyx_22050078_ifu_pkg::CPU_WIDTH,
  parameter int INST_WIDTH = ysyx_22050078_ifu_pkg::INST_WIDTH
);
  logic                  i_pc_valid;
  logic [CPU_WIDTH-1:0]  i_pc;
  logic                  o_pc_ready;
  logic                  i_flush;
  logic                  o_req_valid;
  logic [CPU_WIDTH-1:0]  o_req_addr;
  logic                  i_req_ready;
  logic                  i_rsp_valid;
  logic [CPU_WIDTH-1:0]  i_rsp_data;
  logic                  i_rsp_err;
  logic                  o_inst_valid;
  logic [INST_WIDTH-1:0] o_inst;
  logic [CPU_WIDTH-1:0]  o_inst_pc;
  logic                  o_fault;
  logic [1:0]            o_fault_cause;
  logic                  i_inst_ready;

  // master: the fetch unit itself; slave: PC unit, memory and IDU around it
  modport master (
    input  i_pc_valid, i_pc, i_flush, i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err, i_inst_ready,
    output o_pc_ready, o_req_valid, o_req_addr, o_inst_valid, o_inst, o_inst_pc, o_fault, o_fault_cause
  );

  modport slave (
    output i_pc_valid, i_pc, i_flush, i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err, i_inst_ready,
    input  o_pc_ready, o_req_valid, o_req_addr, o_inst_valid, o_inst, o_inst_pc, o_fault, o_fault_cause
  );
endinterface

// File: rtl/ysyx_22050078_ifu_timer.sv
// Saturating wait counter; o_expired fires in the cycle whose increment would reach TIMEOUT.
module ysyx_22050078_ifu_timer #(
  parameter int TIMEOUT = 255,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                             cnt_d = '0;
    else if (i_en && cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_expired = i_en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: one PC at a time, single-beat memory read, registered instruction to the IDU.
module ysyx_22050078_ifu #(
  parameter int CPU_WIDTH  = 64,
  parameter int INST_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22050078_ifu_if.master  bus
);
  import ysyx_22050078_ifu_pkg::*;

  ifu_state_e            state_q, state_d;
  ifu_fc_e               cause_q, cause_d;
  logic [CPU_WIDTH-1:0]  pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  drop_q, drop_d;
  logic                  expired;
  logic                  dropping;

  ysyx_22050078_ifu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (state_d != state_q),
    .i_en      (state_q == IFU_REQ || state_q == IFU_WAIT),
    .o_expired (expired)
  );

  // A flush arriving in the same cycle as the terminating event still discards the fetch.
  assign dropping = drop_q || bus.i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_IDLE;
      cause_q <= IFU_FC_NONE;
      pc_q    <= '0;
      inst_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    unique case (state_q)
      IFU_IDLE: begin
        if (bus.i_pc_valid && !bus.i_flush) begin
          pc_d   = bus.i_pc;
          inst_d = '0;
          if (bus.i_pc[1:0] != 2'b00) begin
            cause_d = IFU_FC_MISALIGN;
            state_d = IFU_HOLD;
          end else begin
            cause_d = IFU_FC_NONE;
            state_d = IFU_REQ;
          end
        end
      end
      IFU_REQ: begin
        if (bus.i_flush) drop_d = 1'b1;
        if (bus.i_req_ready) begin
          state_d = IFU_WAIT;
        end else if (expired) begin
          drop_d = 1'b0;
          if (dropping) state_d = IFU_IDLE;
          else begin
            state_d = IFU_HOLD;
            cause_d = IFU_FC_TIMEOUT;
            inst_d  = '0;
          end
        end
      end
      IFU_WAIT: begin
        if (bus.i_flush) drop_d = 1'b1;
        if (bus.i_rsp_valid || expired) begin
          drop_d = 1'b0;
          if (dropping) begin
            state_d = IFU_IDLE;
          end else if (bus.i_rsp_valid) begin
            state_d = IFU_HOLD;
            inst_d  = ifu_sel_inst(bus.i_rsp_data, pc_q[2]);
            cause_d = bus.i_rsp_err ? IFU_FC_BUSERR : IFU_FC_NONE;
          end else begin
            state_d = IFU_HOLD;
            cause_d = IFU_FC_TIMEOUT;
            inst_d  = '0;
          end
        end
      end
      IFU_HOLD: begin
        if (bus.i_flush || bus.i_inst_ready) state_d = IFU_IDLE;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    bus.o_pc_ready   = (state_q == IFU_IDLE) && !bus.i_flush;
    bus.o_req_valid  = (state_q == IFU_REQ);
    bus.o_inst_valid = (state_q == IFU_HOLD);
    bus.o_fault      = (state_q == IFU_HOLD) && (cause_q != IFU_FC_NONE);
  end

  assign bus.o_req_addr    = {pc_q[CPU_WIDTH-1:3], 3'b000};
  assign bus.o_inst        = inst_q;
  assign bus.o_inst_pc     = pc_q;
  assign bus.o_fault_cause = cause_q;

endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// Directed bench for the fetch unit with TIMEOUT shortened to 8 cycles.
module tb_ysyx_22050078_ifu;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ysyx_22050078_ifu_if #(.CPU_WIDTH(64), .INST_WIDTH(32)) bus ();

  ysyx_22050078_ifu #(.CPU_WIDTH(64), .INST_WIDTH(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_pc_valid   = 1'b0;
    bus.i_pc         = '0;
    bus.i_flush      = 1'b0;
    bus.i_req_ready  = 1'b0;
    bus.i_rsp_valid  = 1'b0;
    bus.i_rsp_data   = '0;
    bus.i_rsp_err    = 1'b0;
    bus.i_inst_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk("rst_req_valid",  bus.o_req_valid,   64'd0);
    chk("rst_inst_valid", bus.o_inst_valid,  64'd0);
    chk("rst_fault",      bus.o_fault,       64'd0);
    chk("rst_cause",      bus.o_fault_cause, 64'd0);
    chk("rst_inst",       bus.o_inst,        64'd0);
    chk("rst_inst_pc",    bus.o_inst_pc,     64'd0);
    rst = 1'b0;

    // best-case fetch, low word
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0000;
    bus.i_req_ready = 1'b1; bus.i_inst_ready = 1'b1;
    bus.i_rsp_data = 64'h0000_0013_0000_0297;
    chk("t1_c0_pc_ready", bus.o_pc_ready, 64'd1);
    step();
    bus.i_pc_valid = 1'b0;
    chk("t1_c1_req_valid", bus.o_req_valid, 64'd1);
    chk("t1_c1_req_addr",  bus.o_req_addr,  64'h8000_0000);
    chk("t1_c1_pc_ready",  bus.o_pc_ready,  64'd0);
    step();
    bus.i_rsp_valid = 1'b1;
    chk("t1_c2_inst_valid", bus.o_inst_valid, 64'd0);
    step();
    bus.i_rsp_valid = 1'b0;
    chk("t1_c3_inst_valid", bus.o_inst_valid, 64'd1);
    chk("t1_c3_inst",       bus.o_inst,       64'h0000_0297);
    chk("t1_c3_inst_pc",    bus.o_inst_pc,    64'h8000_0000);
    chk("t1_c3_fault",      bus.o_fault,      64'd0);
    step();
    chk("t1_c4_pc_ready",   bus.o_pc_ready,   64'd1);
    chk("t1_c4_inst_valid", bus.o_inst_valid, 64'd0);

    // high word, IDU stalls 5 cycles
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0004; bus.i_inst_ready = 1'b0;
    step();
    bus.i_pc_valid = 1'b0;
    chk("t2_req_addr", bus.o_req_addr, 64'h8000_0000);
    step();
    bus.i_rsp_valid = 1'b1;
    step();
    bus.i_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", bus.o_inst_valid, 64'd1);
      chk("t2_hold_inst",  bus.o_inst,       64'h0000_0013);
      chk("t2_hold_pc",    bus.o_inst_pc,    64'h8000_0004);
      chk("t2_pc_ready",   bus.o_pc_ready,   64'd0);
      step();
    end
    chk("t2_still_held", bus.o_inst_valid, 64'd1);
    bus.i_inst_ready = 1'b1;
    step();
    chk("t2_released", bus.o_pc_ready, 64'd1);

    // misaligned pc: no bus access
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0002;
    step();
    bus.i_pc_valid = 1'b0;
    chk("t3_req_valid",  bus.o_req_valid,   64'd0);
    chk("t3_inst_valid", bus.o_inst_valid,  64'd1);
    chk("t3_fault",      bus.o_fault,       64'd1);
    chk("t3_cause",      bus.o_fault_cause, 64'd1);
    chk("t3_inst",       bus.o_inst,        64'd0);
    chk("t3_inst_pc",    bus.o_inst_pc,     64'h8000_0002);
    step();

    // flush while waiting for the response
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0000;
    step();
    bus.i_pc_valid = 1'b0;
    step();
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    chk("t4_drop_c3", bus.o_inst_valid, 64'd0);
    step();
    bus.i_rsp_valid = 1'b1;
    chk("t4_drop_c4", bus.o_inst_valid, 64'd0);
    step();
    bus.i_rsp_valid = 1'b0;
    chk("t4_drop_c5_valid", bus.o_inst_valid, 64'd0);
    chk("t4_drop_c5_ready", bus.o_pc_ready,   64'd1);
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0010;
    bus.i_rsp_data = 64'hDEAD_BEEF_00A0_0093;
    step();
    bus.i_pc_valid = 1'b0;
    chk("t4_next_addr", bus.o_req_addr, 64'h8000_0010);
    step();
    bus.i_rsp_valid = 1'b1;
    step();
    bus.i_rsp_valid = 1'b0;
    chk("t4_next_valid", bus.o_inst_valid, 64'd1);
    chk("t4_next_inst",  bus.o_inst,       64'h00A0_0093);
    chk("t4_next_pc",    bus.o_inst_pc,    64'h8000_0010);
    chk("t4_next_fault", bus.o_fault,      64'd0);
    step();

    // request never accepted -> timeout 8 cycles after entering REQ
    bus.i_req_ready = 1'b0;
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0020;
    step();
    bus.i_pc_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t5_req_held",    bus.o_req_valid,  64'd1);
      chk("t5_no_inst_yet", bus.o_inst_valid, 64'd0);
      step();
    end
    chk("t5_to_valid", bus.o_inst_valid,  64'd1);
    chk("t5_to_cause", bus.o_fault_cause, 64'd3);
    chk("t5_to_fault", bus.o_fault,       64'd1);
    chk("t5_to_inst",  bus.o_inst,        64'd0);
    chk("t5_to_req",   bus.o_req_valid,   64'd0);
    step();

    // bus error response keeps the selected data
    bus.i_req_ready = 1'b1;
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0004;
    bus.i_rsp_data = 64'h1122_3344_5566_7788;
    step();
    bus.i_pc_valid = 1'b0;
    step();
    bus.i_rsp_valid = 1'b1; bus.i_rsp_err = 1'b1;
    step();
    bus.i_rsp_valid = 1'b0; bus.i_rsp_err = 1'b0;
    chk("t6_err_valid", bus.o_inst_valid,  64'd1);
    chk("t6_err_cause", bus.o_fault_cause, 64'd2);
    chk("t6_err_fault", bus.o_fault,       64'd1);
    chk("t6_err_inst",  bus.o_inst,        64'h1122_3344);
    step();

    // asynchronous reset in REQ
    bus.i_req_ready = 1'b0;
    bus.i_pc_valid = 1'b1; bus.i_pc = 64'h8000_0008;
    step();
    bus.i_pc_valid = 1'b0;
    chk("t7_req_before", bus.o_req_valid, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_req_async", bus.o_req_valid, 64'd0);
    step();
    rst = 1'b0;
    bus.i_rsp_valid = 1'b1;
    step();
    bus.i_rsp_valid = 1'b0;
    chk("t7_pc_ready",   bus.o_pc_ready,   64'd1);
    chk("t7_inst_valid", bus.o_inst_valid, 64'd0);
    chk("t7_req_valid",  bus.o_req_valid,  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050078_ifu.md
# ysyx_22050078_ifu

Instruction fetch unit: the consumer side of the PC interface. Accepts one PC at a time from the PC unit via a valid/ready handshake, issues a single-beat read on the instruction memory bus, and presents the selected 32-bit instruction with its PC to the IDU. Supports redirect flush, misaligned-PC detection, and a bus timeout so the core never hangs silently.

## Interface
- `CPU_WIDTH`, 64: PC and bus data width.
- `INST_WIDTH`, 32: instruction width.
- `TIMEOUT`, 255: max cycles waiting in REQ or WAIT before a fault; counter width is $clog2(TIMEOUT+1).
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_pc_valid`  input  1  PC unit offers a PC.
- `i_pc`  input  CPU_WIDTH  PC to fetch.
- `o_pc_ready`  output  1  fetch unit accepts the PC this cycle.
- `i_flush`  input  1  redirect; discard any fetch in progress.
- `o_req_valid`  output  1  memory read request.
- `o_req_addr`  output  CPU_WIDTH  {pc[63:3], 3'b000}.
- `i_req_ready`  input  1  memory accepts request.
- `i_rsp_valid`  input  1  read data valid.
- `i_rsp_data`  input  CPU_WIDTH  aligned doubleword.
- `i_rsp_err`  input  1  bus error with response.
- `o_inst_valid`  output  1  instruction available to IDU.
- `o_inst`  output  INST_WIDTH  instruction.
- `o_inst_pc`  output  CPU_WIDTH  PC of `o_inst`.
- `o_fault`  output  1  qualified by `o_inst_valid`; fetch faulted.
- `o_fault_cause`  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout.
- `i_inst_ready`  input  1  IDU consumes the instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset to IDLE; all outputs 0, `o_fault_cause` 0, drop flag 0, timeout counter 0.
- IDLE: `o_pc_ready` = !i_flush. On `i_pc_valid && o_pc_ready`: latch PC. If pc[1:0] != 0 go to HOLD with fault cause 1, no bus access; else go to REQ.
- REQ: `o_req_valid` = 1 and held with stable address until `i_req_ready`; then WAIT. Flush does not withdraw a request; it sets the drop flag.
- WAIT: on `i_rsp_valid`: if drop flag, clear it and go IDLE; else latch `o_inst` = pc[2] ? data[63:32] : data[31:0], fault cause 2 if `i_rsp_err`, go HOLD. Response in any other state is ignored.
- HOLD: `o_inst_valid` = 1, outputs stable until `i_inst_ready`; then IDLE. `i_flush` in HOLD drops the instruction and goes IDLE, ignoring `i_inst_ready`.
- Flush in IDLE: no state change. Flush while drop flag already set: no further effect.
- Timeout: counter clears on entry to REQ and WAIT and increments each cycle in them. On reaching TIMEOUT without the expected handshake: if not dropping, go HOLD with cause 3 and `o_inst` = 0; if dropping, go IDLE. Either way clear drop flag. A later stale response is ignored.
- Instruction-field priority on a faulted fetch: `o_inst` = 0 for causes 1 and 3; bus data still selected for cause 2.

## Timing
- No combinational path from `i_rsp_*` to `o_inst*`; all IDU outputs are registered.
- Best-case latency with `i_req_ready` and `i_rsp_valid` asserted at first opportunity: PC accepted at cycle 0, `o_req_valid` at cycle 1, response at cycle 2, `o_inst_valid` at cycle 3.
- Back-to-back throughput: one instruction per 4 cycles when the IDU is always ready. `o_pc_ready` rises the cycle after the IDU handshake.
- Misaligned PC: `o_inst_valid` at cycle 1 with cause 1.
- `o_pc_ready` is 0 in every state except IDLE.
- Reset asserted mid-fetch returns the unit to IDLE asynchronously. A response arriving after reset release is ignored because the state is not WAIT.

## Structure
- Shared package/defines: `CPU_WIDTH`, `INST_WIDTH`, state encoding `IFU_IDLE/REQ/WAIT/HOLD`, and fault cause constants `IFU_FC_NONE/MISALIGN/BUSERR/TIMEOUT`.
- One natural sub-module: `ysyx_22050078_ifu_timer`, the saturating timeout counter with clear/enable and a `o_expired` output.

## Test plan
- Fetch at pc=0x80000000, mem returns 0x0000_0013_0000_0297, all readys high → `o_inst_valid` at cycle 3, `o_inst`=0x00000297, `o_inst_pc`=0x80000000, `o_fault`=0.
- pc=0x80000004, same data, `i_inst_ready` low 5 cycles → `o_inst`=0x00000013 held stable for 5 cycles; `o_pc_ready`=0 throughout.
- pc=0x80000002 → no `o_req_valid`; cycle 1 `o_inst_valid`=1, `o_fault`=1, cause 1, `o_inst`=0.
- Flush during WAIT at pc=0x80000000, response 2 cycles later → no `o_inst_valid`. Next PC 0x80000010 fetches normally with its own data.
- `i_req_ready` held low and TIMEOUT=8 → `o_inst_valid` with cause 3 exactly 8 cycles after entering REQ. Repeat with `i_rsp_err`=1 → cause 2.
- Reset asserted during REQ → `o_req_valid` drops immediately. After release, state is IDLE and `o_pc_ready`=1.
